// File: rtl/riscv_v_dispatch_queue_if.sv
// riscv_v_dispatch_queue_if: scalar-side offer and vector-side head signals of the dispatch queue.
interface riscv_v_dispatch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
);
    logic                     clear_pipe;
    logic                     in_valid;
    logic [ILEN-1:0]          in_instruction;
    logic [XLEN-1:0]          in_rs1_data;
    logic                     in_ready;
    logic                     scalar_stall;
    logic                     v_stall;
    logic                     v_valid;
    logic [ILEN-1:0]          v_instruction;
    logic [XLEN-1:0]          v_rs1_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output clear_pipe, in_valid, in_instruction, in_rs1_data, v_stall,
        input  in_ready, scalar_stall, v_valid, v_instruction, v_rs1_data, count
    );

    modport slave (
        input  clear_pipe, in_valid, in_instruction, in_rs1_data, v_stall,
        output in_ready, scalar_stall, v_valid, v_instruction, v_rs1_data, count
    );
endinterface

// File: rtl/riscv_v_dispatch_queue.sv
// riscv_v_dispatch_queue: FIFO buffering vector instructions and rs1 operands from scalar ID to the vector unit.
module riscv_v_dispatch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [ILEN-1:0] NOP_INST = 32'h0000_0013
) (
    input logic                     clk,
    input logic                     rst,
    riscv_v_dispatch_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ILEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push, pop;

    assign q.in_ready      = cnt != CW'(DEPTH);
    assign q.scalar_stall  = q.in_valid & ~q.in_ready;
    assign q.v_valid       = cnt != '0;
    assign q.v_instruction = q.v_valid ? inst_mem[rd_ptr] : NOP_INST;
    assign q.v_rs1_data    = q.v_valid ? data_mem[rd_ptr] : '0;
    assign q.count         = cnt;
    assign push            = q.in_valid & q.in_ready & ~q.clear_pipe;
    assign pop             = q.v_valid & ~q.v_stall & ~q.clear_pipe;

    // Storage is deliberately unreset; validity comes from cnt alone.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= q.in_instruction;
            data_mem[wr_ptr] <= q.in_rs1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (q.clear_pipe) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_riscv_v_dispatch_queue.sv
// tb_riscv_v_dispatch_queue: directed vectors plus a randomized scoreboard run for the dispatch queue.
module tb_riscv_v_dispatch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] model [$];

    riscv_v_dispatch_queue_if #(.DEPTH(4), .XLEN(32), .ILEN(32)) q ();

    riscv_v_dispatch_queue #(.DEPTH(4), .XLEN(32), .ILEN(32), .NOP_INST(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .q  (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] inst, input logic [31:0] rs1);
        q.in_valid       = v;
        q.in_instruction = inst;
        q.in_rs1_data    = rs1;
    endtask

    initial begin
        q.clear_pipe = 1'b0;
        q.v_stall    = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_count", 64'(q.count), 64'd0);
        chk("rst_in_ready", 64'(q.in_ready), 64'd1);
        chk("rst_scalar_stall", 64'(q.scalar_stall), 64'd0);
        chk("rst_v_valid", 64'(q.v_valid), 64'd0);
        chk("rst_v_inst", 64'(q.v_instruction), 64'(NOP));
        chk("rst_v_rs1", 64'(q.v_rs1_data), 64'd0);
        rst = 1'b0;

        offer(1'b1, 32'h0000_1057, 32'h10);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("push_v_valid", 64'(q.v_valid), 64'd1);
        chk("push_v_inst", 64'(q.v_instruction), 64'h1057);
        chk("push_v_rs1", 64'(q.v_rs1_data), 64'h10);
        chk("push_count", 64'(q.count), 64'd1);
        tick();
        chk("pop_count", 64'(q.count), 64'd0);
        chk("pop_v_inst", 64'(q.v_instruction), 64'(NOP));
        chk("pop_v_valid", 64'(q.v_valid), 64'd0);

        q.v_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'h100 + 32'(i), 32'(i));
            tick();
        end
        offer(1'b1, 32'h104, 32'd4);
        #1;
        chk("full_count", 64'(q.count), 64'd4);
        chk("full_in_ready", 64'(q.in_ready), 64'd0);
        chk("full_scalar_stall", 64'(q.scalar_stall), 64'd1);
        tick();
        chk("full_hold_count", 64'(q.count), 64'd4);
        chk("full_hold_head", 64'(q.v_instruction), 64'h100);
        chk("full_hold_rs1", 64'(q.v_rs1_data), 64'd0);

        q.v_stall = 1'b0;
        tick();
        chk("release_count", 64'(q.count), 64'd3);
        chk("release_head", 64'(q.v_instruction), 64'h101);
        for (int k = 0; k < 6; k++) begin
            offer(1'b1, 32'h104 + 32'(k), 32'd4 + 32'(k));
            tick();
            chk("overlap_count", 64'(q.count), 64'd3);
            chk("overlap_head", 64'(q.v_instruction), 64'h102 + 64'(k));
            chk("overlap_rs1", 64'(q.v_rs1_data), 64'd2 + 64'(k));
        end

        offer(1'b1, 32'hDEAD_0057, 32'hBAD);
        q.clear_pipe = 1'b1;
        tick();
        q.clear_pipe = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        chk("clear_count", 64'(q.count), 64'd0);
        chk("clear_v_valid", 64'(q.v_valid), 64'd0);
        chk("clear_v_inst", 64'(q.v_instruction), 64'(NOP));
        tick();
        chk("clear_dropped", 64'(q.v_valid), 64'd0);

        q.v_stall = 1'b1;
        offer(1'b1, 32'h200, 32'h20);
        tick();
        offer(1'b1, 32'h201, 32'h21);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("pre_arst_count", 64'(q.count), 64'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_v_valid", 64'(q.v_valid), 64'd0);
        chk("arst_count", 64'(q.count), 64'd0);
        chk("arst_v_inst", 64'(q.v_instruction), 64'(NOP));
        #1 rst = 1'b0;
        q.v_stall = 1'b0;
        offer(1'b1, 32'h300, 32'h30);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("post_arst_head", 64'(q.v_instruction), 64'h300);
        chk("post_arst_count", 64'(q.count), 64'd1);
        tick();
        chk("post_arst_drain", 64'(q.count), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            logic do_push, do_pop;
            offer(1'($urandom_range(0, 1)), $urandom, $urandom);
            q.v_stall = ($urandom_range(0, 3) == 0);
            #1;
            chk("rand_count", 64'(q.count), 64'(model.size()));
            do_push = q.in_valid && model.size() < 4;
            do_pop  = model.size() != 0 && !q.v_stall;
            if (do_pop) chk("rand_head", {q.v_instruction, q.v_rs1_data}, model[0]);
            @(posedge clk);
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back({q.in_instruction, q.in_rs1_data});
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
